// File: rtl/hht_mem_responder_if.sv
// hht_mem_responder_if: request/response bundle shared by the HHT responder and its driver
//   p{0,1}_req_valid/addr/ready : read request handshake (port 0 backend, port 1 frontend)
//   p{0,1}_rsp_valid/data/ready : in-order read response handshake per port
//   ld_en/ld_addr/ld_data       : store write strobe, word address, data
//   err                         : sticky out-of-range flag
interface hht_mem_responder_if;
   logic        p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready;
   logic [31:0] p0_req_addr, p0_rsp_data;
   logic        p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready;
   logic [31:0] p1_req_addr, p1_rsp_data;
   logic        ld_en;
   logic [31:0] ld_addr, ld_data;
   logic        err;
   modport master (
      output p0_req_valid, p0_req_addr, p0_rsp_ready,
      output p1_req_valid, p1_req_addr, p1_rsp_ready,
      output ld_en, ld_addr, ld_data,
      input  p0_req_ready, p0_rsp_valid, p0_rsp_data,
      input  p1_req_ready, p1_rsp_valid, p1_rsp_data,
      input  err
   );
   modport slave (
      input  p0_req_valid, p0_req_addr, p0_rsp_ready,
      input  p1_req_valid, p1_req_addr, p1_rsp_ready,
      input  ld_en, ld_addr, ld_data,
      output p0_req_ready, p0_rsp_valid, p0_rsp_data,
      output p1_req_ready, p1_rsp_valid, p1_rsp_data,
      output err
   );
endinterface

// File: rtl/hht_mem_responder.sv
// hht_mem_responder: two-port round-robin read responder over a word-addressed store
//   clk   : clock
//   reset : synchronous, active-low reset (store contents are kept)
//   bus   : slave side of hht_mem_responder_if (both read ports, load port, err)
module hht_mem_responder #(
   parameter int DEPTH     = 256,
   parameter int RD_LAT    = 2,
   parameter int RSP_DEPTH = 4
) (
   input logic                clk,
   input logic                reset,
   hht_mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   logic [31:0]       mem [DEPTH];
   logic [1:0]        vld, rdy, acc, pop, elig, push, rsp_v, rsp_rdy;
   logic [31:0]       addr [2];
   logic [CW-1:0]     out_cnt [2];
   logic [CW-1:0]     f_cnt [2];
   logic [FW-1:0]     wp [2];
   logic [FW-1:0]     rp [2];
   logic [31:0]       fbuf [2][RSP_DEPTH];
   logic [RD_LAT-1:0] pv, pp;
   logic [31:0]       pd [RD_LAT];
   logic [31:0]       raddr, rdata;
   logic              rr, rd_oor, ld_oor, err_q;
   assign vld     = {bus.p1_req_valid, bus.p0_req_valid};
   assign rsp_rdy = {bus.p1_rsp_ready, bus.p0_rsp_ready};
   assign addr[0] = bus.p0_req_addr;
   assign addr[1] = bus.p1_req_addr;
   // out_cnt covers both in-flight pipeline entries and FIFO occupancy, so a
   // port is only eligible when its FIFO is guaranteed to have room on arrival
   assign elig[0] = reset && !bus.ld_en && out_cnt[0] < CW'(RSP_DEPTH);
   assign elig[1] = reset && !bus.ld_en && out_cnt[1] < CW'(RSP_DEPTH);
   // a port yields only when the other is eligible, valid and holds the pointer
   assign rdy[0]  = elig[0] && !(elig[1] && vld[1] && rr);
   assign rdy[1]  = elig[1] && !(elig[0] && vld[0] && !rr);
   assign acc     = vld & rdy;
   assign rsp_v   = {f_cnt[1] != '0, f_cnt[0] != '0};
   assign pop     = rsp_v & rsp_rdy;
   assign raddr   = acc[1] ? addr[1] : addr[0];
   assign rd_oor  = raddr >= 32'(DEPTH);
   assign ld_oor  = bus.ld_addr >= 32'(DEPTH);
   assign rdata   = rd_oor ? 32'd0 : mem[raddr[AW-1:0]];
   assign push    = {pv[RD_LAT-1] & pp[RD_LAT-1], pv[RD_LAT-1] & ~pp[RD_LAT-1]};
   assign bus.p0_req_ready = rdy[0];
   assign bus.p1_req_ready = rdy[1];
   assign bus.p0_rsp_valid = rsp_v[0];
   assign bus.p1_rsp_valid = rsp_v[1];
   assign bus.p0_rsp_data  = fbuf[0][rp[0]];
   assign bus.p1_rsp_data  = fbuf[1][rp[1]];
   assign bus.err          = err_q;
   always_ff @(posedge clk) begin
      if (bus.ld_en && !ld_oor) mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr    <= 1'b0;
         err_q <= 1'b0;
         pv    <= '0;
         pp    <= '0;
         for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
         for (int k = 0; k < 2; k++) begin
            out_cnt[k] <= '0;
            f_cnt[k]   <= '0;
            wp[k]      <= '0;
            rp[k]      <= '0;
            for (int j = 0; j < RSP_DEPTH; j++) fbuf[k][j] <= '0;
         end
      end else begin
         rr    <= acc[0] ? 1'b1 : acc[1] ? 1'b0 : rr;
         err_q <= err_q | (|acc && rd_oor) | (bus.ld_en && ld_oor);
         pv[0] <= |acc;
         pp[0] <= acc[1];
         pd[0] <= rdata;
         for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pp[i] <= pp[i-1];
            pd[i] <= pd[i-1];
         end
         for (int k = 0; k < 2; k++) begin
            out_cnt[k] <= out_cnt[k] + CW'(acc[k]) - CW'(pop[k]);
            f_cnt[k]   <= f_cnt[k] + CW'(push[k]) - CW'(pop[k]);
            if (push[k]) begin
               fbuf[k][wp[k]] <= pd[RD_LAT-1];
               wp[k]          <= (wp[k] == FW'(RSP_DEPTH - 1)) ? '0 : wp[k] + 1'b1;
            end
            if (pop[k]) rp[k] <= (rp[k] == FW'(RSP_DEPTH - 1)) ? '0 : rp[k] + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hht_mem_responder.sv
// tb_hht_mem_responder: scoreboard bench for hht_mem_responder with a queue-based reference model
//   drives both read ports and the load port through hht_mem_responder_if; a negedge monitor
//   checks readiness, err, response data/order/latency against the model
module tb_hht_mem_responder;
   localparam int DEPTH = 256, RD_LAT = 2, RSP_DEPTH = 4;
   localparam int AW = $clog2(DEPTH);
   typedef struct {
      logic [31:0] d;
      int          t;
   } exp_t;
   logic clk = 1'b0, reset = 1'b0;
   int   n_checks = 0, n_fail = 0, cyc = 0;
   bit   chk_en = 1'b0;
   hht_mem_responder_if bus();
   hht_mem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   logic [1:0]  req_v, req_r, rsp_v, rsp_r;
   logic [31:0] req_a [2];
   logic [31:0] rsp_d [2];
   assign req_v    = {bus.p1_req_valid, bus.p0_req_valid};
   assign req_r    = {bus.p1_req_ready, bus.p0_req_ready};
   assign rsp_v    = {bus.p1_rsp_valid, bus.p0_rsp_valid};
   assign rsp_r    = {bus.p1_rsp_ready, bus.p0_rsp_ready};
   assign req_a[0] = bus.p0_req_addr;
   assign req_a[1] = bus.p1_req_addr;
   assign rsp_d[0] = bus.p0_rsp_data;
   assign rsp_d[1] = bus.p1_rsp_data;
   logic [31:0] ref_mem [DEPTH];
   exp_t        sb [2][$];
   bit          rr_m = 1'b0, err_m = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // reference model: outstanding count per port is simply the scoreboard queue length
   always @(negedge clk) begin
      logic [1:0] el, xr;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) el[k] = reset && !bus.ld_en && sb[k].size() < RSP_DEPTH;
         xr[0] = el[0] && !(el[1] && req_v[1] && rr_m);
         xr[1] = el[1] && !(el[0] && req_v[0] && !rr_m);
         chk("p0_req_ready", 32'(req_r[0]), 32'(xr[0]));
         chk("p1_req_ready", 32'(req_r[1]), 32'(xr[1]));
         chk("err", 32'(bus.err), 32'(err_m));
         for (int k = 0; k < 2; k++) begin
            if (rsp_v[k]) begin
               if (sb[k].size() == 0) chk($sformatf("p%0d_rsp_unexpected", k), 32'd1, 32'd0);
               else begin
                  chk($sformatf("p%0d_rsp_data", k), rsp_d[k], sb[k][0].d);
                  chk($sformatf("p%0d_rsp_too_early", k), 32'(cyc - sb[k][0].t >= RD_LAT + 1), 32'd1);
                  if (rsp_r[k]) void'(sb[k].pop_front());
               end
            end
         end
         if (bus.ld_en) begin
            if (bus.ld_addr < 32'(DEPTH)) ref_mem[bus.ld_addr[AW-1:0]] = bus.ld_data;
            else err_m = 1'b1;
         end
         if (!reset) begin
            sb[0].delete();
            sb[1].delete();
            rr_m  = 1'b0;
            err_m = 1'b0;
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (req_v[k] && req_r[k]) begin
                  sb[k].push_back('{d: (req_a[k] < 32'(DEPTH)) ? ref_mem[req_a[k][AW-1:0]] : 32'd0, t: cyc});
                  rr_m = (k == 0);
                  if (req_a[k] >= 32'(DEPTH)) err_m = 1'b1;
               end
            end
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // returns at the negedge preceding the accepting edge
   task automatic wait_acc(input int k);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_v[k] && req_r[k]) return;
      end
      chk($sformatf("p%0d_accept_timeout", k), 32'd0, 32'd1);
   endtask
   function automatic logic [31:0] rand_addr();
      return ($urandom_range(0, 99) < 5) ? 32'($urandom_range(256, 100000)) : 32'($urandom_range(0, 255));
   endfunction
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before timeout");
      $fatal(1);
   end
   initial begin
      int lat, n0, n1, idx;
      bit seen;
      bus.p0_req_valid = 0; bus.p0_req_addr = 0; bus.p0_rsp_ready = 1;
      bus.p1_req_valid = 0; bus.p1_req_addr = 0; bus.p1_rsp_ready = 1;
      bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;
      repeat (2) @(posedge clk);
      #1 chk_en = 1;
      step();
      reset = 1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.ld_en   = 1;
         bus.ld_addr = 32'(i);
         bus.ld_data = (i < 8) ? 32'(100 + i) : $urandom;
         step();
      end
      bus.ld_en = 0;
      // T1: single read, exact latency
      bus.p0_req_valid = 1; bus.p0_req_addr = 3;
      wait_acc(0);
      step();
      bus.p0_req_valid = 0;
      lat = 1; seen = 0;
      while (!seen && lat < 12) begin
         @(negedge clk);
         if (bus.p0_rsp_valid) seen = 1; else lat++;
      end
      chk("t1_latency", 32'(lat), 32'(RD_LAT + 1));
      // T2: both ports saturate, grants alternate
      repeat (4) step();
      bus.p0_req_valid = 1; bus.p0_req_addr = 1;
      bus.p1_req_valid = 1; bus.p1_req_addr = 5;
      n0 = 0; n1 = 0;
      repeat (20) begin
         @(negedge clk);
         n0 += int'(req_v[0] && req_r[0]);
         n1 += int'(req_v[1] && req_r[1]);
         step();
      end
      bus.p0_req_valid = 0; bus.p1_req_valid = 0;
      chk("t2_p0_grants", 32'(n0), 32'd10);
      chk("t2_p1_grants", 32'(n1), 32'd10);
      // T3: credit exhaustion with consumer stalled
      repeat (4) step();
      bus.p0_rsp_ready = 0;
      idx = 0; n0 = 0;
      bus.p0_req_valid = 1; bus.p0_req_addr = 0;
      repeat (8) begin
         @(negedge clk);
         if (req_v[0] && req_r[0]) begin n0++; idx++; end
         step();
         bus.p0_req_valid = (idx < 6); bus.p0_req_addr = 32'(idx);
      end
      chk("t3_accepted_while_blocked", 32'(n0), 32'd4);
      bus.p0_rsp_ready = 1;
      for (int i = 0; i < 20 && idx < 6; i++) begin
         @(negedge clk);
         if (req_v[0] && req_r[0]) idx++;
         step();
         bus.p0_req_valid = (idx < 6); bus.p0_req_addr = 32'(idx);
      end
      bus.p0_req_valid = 0;
      chk("t3_all_accepted", 32'(idx), 32'd6);
      // T4: load takes priority, following read sees new data
      repeat (6) step();
      bus.ld_en = 1; bus.ld_addr = 2; bus.ld_data = 32'hDEAD;
      bus.p0_req_valid = 1; bus.p0_req_addr = 2;
      @(negedge clk);
      chk("t4_stall_on_load", 32'(req_r[0]), 32'd0);
      step();
      bus.ld_en = 0;
      wait_acc(0);
      step();
      bus.p0_req_valid = 0;
      // T5: out-of-range read then legal read
      bus.p1_req_valid = 1; bus.p1_req_addr = 300;
      wait_acc(1);
      step();
      bus.p1_req_addr = 4;
      wait_acc(1);
      step();
      bus.p1_req_valid = 0;
      repeat (6) step();
      @(negedge clk);
      chk("t5_err_sticky", 32'(bus.err), 32'd1);
      // random traffic, loads kept away from addresses 0..7
      for (int c = 0; c < 400; c++) begin
         bus.p0_req_valid = $urandom_range(0, 99) < 60; bus.p0_req_addr = rand_addr();
         bus.p1_req_valid = $urandom_range(0, 99) < 60; bus.p1_req_addr = rand_addr();
         bus.p0_rsp_ready = $urandom_range(0, 99) < 70;
         bus.p1_rsp_ready = $urandom_range(0, 99) < 70;
         bus.ld_en   = $urandom_range(0, 99) < 8;
         bus.ld_addr = 32'($urandom_range(8, 299));
         bus.ld_data = $urandom;
         step();
      end
      bus.p0_req_valid = 0; bus.p1_req_valid = 0; bus.ld_en = 0;
      bus.p0_rsp_ready = 1; bus.p1_rsp_ready = 1;
      repeat (10) step();
      // T6: reset with three requests in flight
      bus.p0_rsp_ready = 0; bus.p1_rsp_ready = 0;
      bus.p0_req_valid = 1; bus.p0_req_addr = 10;
      wait_acc(0);
      step();
      bus.p0_req_addr = 12;
      wait_acc(0);
      step();
      bus.p0_req_valid = 0;
      bus.p1_req_valid = 1; bus.p1_req_addr = 11;
      wait_acc(1);
      step();
      bus.p1_req_valid = 0;
      reset = 0;
      step();
      @(negedge clk);
      chk("t6_p0_rsp_valid_in_reset", 32'(bus.p0_rsp_valid), 32'd0);
      chk("t6_p1_rsp_valid_in_reset", 32'(bus.p1_rsp_valid), 32'd0);
      chk("t6_err_in_reset", 32'(bus.err), 32'd0);
      step();
      reset = 1;
      bus.p0_rsp_ready = 1; bus.p1_rsp_ready = 1;
      repeat (6) step();
      bus.p0_req_valid = 1; bus.p0_req_addr = 3;
      wait_acc(0);
      step();
      bus.p0_req_valid = 0;
      for (int i = 0; i < 50 && (sb[0].size() + sb[1].size()) != 0; i++) step();
      chk("drain_outstanding", 32'(sb[0].size() + sb[1].size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
